// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: jump flush, multicycle stall with timeout, load-use interlock.
// Optional performance counters are built when PIPE_CTRL_PERF_CNT_EN is defined.
module pipe_ctrl #(
  parameter int FLUSH_LEN       = 2,
  parameter int STALL_TIMEOUT   = 64,
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int INST_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0]  id_rs2_addr_i,
  input  logic                       id_rs1_re_i,
  input  logic                       id_rs2_re_i,
  input  logic                       ex_rd_we_i,
  input  logic [REG_ADDR_WIDTH-1:0]  ex_rd_addr_i,
  input  logic                       ex_is_load_i,
  input  logic                       ex_busy_i,
  input  logic                       jump_req_i,
  input  logic [INST_ADDR_WIDTH-1:0] jump_addr_i,
  output logic                       jump_o,
  output logic [INST_ADDR_WIDTH-1:0] jump_addr_o,
  output logic                       hold_pc_o,
  output logic                       hold_if_id_o,
  output logic                       hold_id_ex_o,
  output logic                       flush_if_id_o,
  output logic                       flush_id_ex_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [31:0]                stall_cnt_o,
  output logic [31:0]                flush_cnt_o,
`endif
  output logic                       timeout_o
);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] STALL = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam int STALL_W = (STALL_TIMEOUT > 0) ? $clog2(STALL_TIMEOUT + 1) : 1;
  localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_TIMEOUT);
  localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
  localparam logic [2:0]         FLUSH_INIT = 3'(FLUSH_LEN - 1);

  logic [1:0]         state_q, state_d;
  logic [2:0]         flush_cnt_q, flush_cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               load_use;

  assign load_use = ex_is_load_i & ex_rd_we_i & (ex_rd_addr_i != '0) &
                    ((id_rs1_re_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                     (id_rs2_re_i & (id_rs2_addr_i == ex_rd_addr_i)));

  // Priority in RUN: jump, then multicycle busy, then load-use interlock.
  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    jump_o        = 1'b0;
    jump_addr_o   = '0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    timeout_o     = 1'b0;
    if (!rst) begin
      case (state_q)
        RUN: begin
          stall_cnt_d = '0;
          if (jump_req_i) begin
            jump_o        = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            flush_cnt_d   = FLUSH_INIT;
            state_d       = (FLUSH_LEN == 1) ? RUN : FLUSH;
          end else if (ex_busy_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            state_d      = STALL;
          end else if (load_use) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end
        end
        FLUSH: begin
          flush_if_id_o = 1'b1;
          if (flush_cnt_q <= 3'd1) begin
            flush_cnt_d = 3'd0;
            state_d     = RUN;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end
        STALL: begin
          if (ex_busy_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            // Saturation at STALL_MAX is what keeps timeout_o from re-pulsing.
            if (stall_cnt_q != STALL_MAX) begin
              stall_cnt_d = stall_cnt_q + STALL_ONE;
              timeout_o   = (stall_cnt_q == STALL_MAX - STALL_ONE);
            end
          end else begin
            stall_cnt_d = '0;
            state_d     = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q + ((hold_pc_o | hold_if_id_o | hold_id_ex_o) ? 32'd1 : 32'd0);
    perf_flush_d = perf_flush_q + (jump_o ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign stall_cnt_o = rst ? 32'd0 : perf_stall_q;
  assign flush_cnt_o = rst ? 32'd0 : perf_flush_q;
`else
  // Performance counters are not present in this build.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl (FLUSH_LEN=2, STALL_TIMEOUT=4): directed vectors
// push hand-computed expectations; an independent monitor compares them each cycle.
module tb_pipe_ctrl;

  typedef struct packed {
    logic        rst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1re;
    logic        rs2re;
    logic        we;
    logic [4:0]  rd;
    logic        load;
    logic        busy;
    logic        jreq;
    logic [31:0] jaddr;
  } in_t;

  typedef struct packed {
    logic        jump;
    logic [31:0] addr;
    logic        hpc;
    logic        hif;
    logic        hex;
    logic        fif;
    logic        fex;
    logic        to;
  } out_t;

  logic        clk;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_rs1_re, id_rs2_re, ex_rd_we, ex_is_load, ex_busy, jump_req;
  logic [31:0] jump_addr_in, jump_addr_out;
  logic        jump, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, timeout;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  out_t  expQ[$];
  string nameQ[$];
  int    checks = 0;
  int    errors = 0;

  pipe_ctrl #(
    .FLUSH_LEN      (2),
    .STALL_TIMEOUT  (4),
    .REG_ADDR_WIDTH (5),
    .INST_ADDR_WIDTH(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1_addr_i(id_rs1_addr),
    .id_rs2_addr_i(id_rs2_addr),
    .id_rs1_re_i  (id_rs1_re),
    .id_rs2_re_i  (id_rs2_re),
    .ex_rd_we_i   (ex_rd_we),
    .ex_rd_addr_i (ex_rd_addr),
    .ex_is_load_i (ex_is_load),
    .ex_busy_i    (ex_busy),
    .jump_req_i   (jump_req),
    .jump_addr_i  (jump_addr_in),
    .jump_o       (jump),
    .jump_addr_o  (jump_addr_out),
    .hold_pc_o    (hold_pc),
    .hold_if_id_o (hold_if_id),
    .hold_id_ex_o (hold_id_ex),
    .flush_if_id_o(flush_if_id),
    .flush_id_ex_o(flush_id_ex),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cnt_o  (stall_cnt),
    .flush_cnt_o  (flush_cnt),
`endif
    .timeout_o    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t ii(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                             input logic s1re, input logic s2re, input logic w,
                             input logic [4:0] d, input logic ld, input logic b,
                             input logic j, input logic [31:0] ja);
    in_t v;
    v = '{r, s1, s2, s1re, s2re, w, d, ld, b, j, ja};
    return v;
  endfunction

  function automatic out_t eo(input logic j, input logic [31:0] a, input logic hp,
                              input logic hi, input logic he, input logic fi,
                              input logic fe, input logic t);
    out_t o;
    o = '{j, a, hp, hi, he, fi, fe, t};
    return o;
  endfunction

  // Drive one cycle of inputs at the falling edge and queue what must be seen.
  task automatic applyStimulus(input string name, input in_t v, input out_t e);
    @(negedge clk);
    rst          = v.rst;
    id_rs1_addr  = v.rs1;
    id_rs2_addr  = v.rs2;
    id_rs1_re    = v.rs1re;
    id_rs2_re    = v.rs2re;
    ex_rd_we     = v.we;
    ex_rd_addr   = v.rd;
    ex_is_load   = v.load;
    ex_busy      = v.busy;
    jump_req     = v.jreq;
    jump_addr_in = v.jaddr;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput();
    out_t  act;
    out_t  e;
    string n;
    e   = expQ.pop_front();
    n   = nameQ.pop_front();
    act = '{jump, jump_addr_out, hold_pc, hold_if_id, hold_id_ex, flush_if_id, flush_id_ex, timeout};
    checks++;
    if (act !== e) begin
      errors++;
      $display("[TB] FAIL %s: got jump=%b addr=%h hold=%b%b%b flush=%b%b to=%b, expected jump=%b addr=%h hold=%b%b%b flush=%b%b to=%b",
               n, act.jump, act.addr, act.hpc, act.hif, act.hex, act.fif, act.fex, act.to,
               e.jump, e.addr, e.hpc, e.hif, e.hex, e.fif, e.fex, e.to);
    end
  endtask

  // Monitor: outputs are combinational, so sample mid low-phase once inputs settle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) checkOutput();
    end
  end

  initial begin
    in_t  idle, hazIn, busyIn;
    out_t zero, fif, haz, hold, holdTo;
    bit   drained;

    rst = 1'b1; id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_re = 1'b0; id_rs2_re = 1'b0;
    ex_rd_we = 1'b0; ex_rd_addr = '0; ex_is_load = 1'b0; ex_busy = 1'b0;
    jump_req = 1'b0; jump_addr_in = '0;

    idle   = ii(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 32'h0);
    hazIn  = ii(0, 5'd3, 5'd5, 0, 1, 1, 5'd5, 1, 0, 0, 32'h0);
    busyIn = ii(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 32'h0);
    zero   = eo(0, 32'h0, 0, 0, 0, 0, 0, 0);
    fif    = eo(0, 32'h0, 0, 0, 0, 1, 0, 0);
    haz    = eo(0, 32'h0, 1, 1, 0, 0, 1, 0);
    hold   = eo(0, 32'h0, 1, 1, 1, 0, 0, 0);
    holdTo = eo(0, 32'h0, 1, 1, 1, 0, 0, 1);

    // Reset masks every output
    applyStimulus("reset_busy_jump", ii(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 32'h80), zero);
    applyStimulus("reset_hazard", ii(1, 5'd3, 5'd5, 0, 1, 1, 5'd5, 1, 0, 0, 32'h0), zero);
    applyStimulus("idle_after_reset", idle, zero);

    // Jump with two flush cycles
    applyStimulus("jump_cycle", ii(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 32'h80),
                  eo(1, 32'h80, 0, 0, 0, 1, 1, 0));
    applyStimulus("flush_second", ii(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 32'h44), fif);
    applyStimulus("run_after_flush", idle, zero);

    // Load-use detection
    applyStimulus("load_use_rs2", hazIn, haz);
    applyStimulus("load_use_rd0", ii(0, 5'd3, 5'd0, 0, 1, 1, 5'd0, 1, 0, 0, 32'h0), zero);
    applyStimulus("load_use_rs1", ii(0, 5'd7, 5'd2, 1, 1, 1, 5'd7, 1, 0, 0, 32'h0), haz);
    applyStimulus("rs1_not_read", ii(0, 5'd7, 5'd2, 0, 1, 1, 5'd7, 1, 0, 0, 32'h0), zero);
    applyStimulus("not_load", ii(0, 5'd7, 5'd7, 1, 1, 1, 5'd7, 0, 0, 0, 32'h0), zero);
    applyStimulus("no_write", ii(0, 5'd7, 5'd7, 1, 1, 0, 5'd7, 1, 0, 0, 32'h0), zero);

    // Three-cycle busy stall
    for (int i = 0; i < 3; i++) applyStimulus("busy3", busyIn, hold);
    applyStimulus("busy_release", idle, zero);
    applyStimulus("run_after_busy", hazIn, haz);

    // Ten busy cycles: timeout on the fifth only
    for (int i = 1; i <= 10; i++) applyStimulus("busy10", busyIn, (i == 5) ? holdTo : hold);
    applyStimulus("busy10_release", idle, zero);

    // Counter cleared on release: timeout fires again; STALL ignores jump/hazard
    applyStimulus("burst2_run", busyIn, hold);
    applyStimulus("stall_ignores_jump", ii(0, 5'd3, 5'd5, 0, 1, 1, 5'd5, 1, 1, 1, 32'h90), hold);
    applyStimulus("burst2", busyIn, hold);
    applyStimulus("burst2", busyIn, hold);
    applyStimulus("burst2_timeout", busyIn, holdTo);
    applyStimulus("stall_exit_ignores_jump", ii(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 32'h99), zero);
    applyStimulus("idle_after_burst2", idle, zero);

    // Jump wins over busy and hazard; FLUSH ignores everything
    applyStimulus("jump_over_busy_hazard", ii(0, 5'd3, 5'd5, 0, 1, 1, 5'd5, 1, 1, 1, 32'h120),
                  eo(1, 32'h120, 0, 0, 0, 1, 1, 0));
    applyStimulus("flush_ignores_all", ii(0, 5'd3, 5'd5, 0, 1, 1, 5'd5, 1, 1, 1, 32'h200), fif);
    applyStimulus("run_after_flush2", idle, zero);

    // Reset in FLUSH
    applyStimulus("jump_again", ii(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 1, 32'h40),
                  eo(1, 32'h40, 0, 0, 0, 1, 1, 0));
    applyStimulus("reset_in_flush", ii(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 32'h40), zero);
    applyStimulus("idle_after_flush_reset", idle, zero);

    // Reset in STALL mid-count; a hazard proves the FSM is back in RUN
    for (int i = 0; i < 3; i++) applyStimulus("busy_pre_reset", busyIn, hold);
    applyStimulus("reset_in_stall", ii(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 32'h0), zero);
    applyStimulus("hazard_after_stall_reset", hazIn, haz);
    for (int i = 1; i <= 5; i++) applyStimulus("busy_after_reset", busyIn, (i == 5) ? holdTo : hold);
    applyStimulus("final_idle", idle, zero);

    drained = 1'b0;
    for (int i = 0; i < 20 && !drained; i++) begin
      @(posedge clk);
      if (expQ.size() == 0) drained = 1'b1;
    end
    if (!drained) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_LEN, default 2: total IF/ID flush cycles per taken jump, legal range 1..4.
REQ-002 SHALL have parameter STALL_TIMEOUT, default 64: stall-cycle count that raises timeout_o; 0 disables the timeout.
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_rs1_addr_i  in  REG_ADDR_WIDTH  ID source register 1 address.
- id_rs2_addr_i  in  REG_ADDR_WIDTH  ID source register 2 address.
- id_rs1_re_i  in  1  ID reads rs1.
- id_rs2_re_i  in  1  ID reads rs2.
- ex_rd_we_i  in  1  EX writes rd.
- ex_rd_addr_i  in  REG_ADDR_WIDTH  EX destination register.
- ex_is_load_i  in  1  EX holds a load.
- ex_busy_i  in  1  EX multicycle unit busy.
- jump_req_i  in  1  EX taken jump/branch.
- jump_addr_i  in  INST_ADDR_WIDTH  jump target.
- jump_o  out  1  redirect PC.
- jump_addr_o  out  INST_ADDR_WIDTH  redirect target.
- hold_pc_o  out  1  freeze PC.
- hold_if_id_o  out  1  freeze IF/ID register.
- hold_id_ex_o  out  1  freeze ID/EX register.
- flush_if_id_o  out  1  IF/ID register loads a bubble.
- flush_id_ex_o  out  1  ID/EX register loads a bubble.
- timeout_o  out  1  one-cycle pulse on stall timeout.

Function
REQ-004 SHALL implement FSM states RUN, STALL and FLUSH, plus a 3-bit flush counter and a stall counter of width clog2(STALL_TIMEOUT+1), minimum 1 bit.
REQ-005 SHALL drive all outputs combinationally from the current state and the current inputs, with zero-cycle latency.
REQ-006 RUN, jump_req_i=1 (highest priority): jump_o=1, jump_addr_o=jump_addr_i, flush_if_id_o=1, flush_id_ex_o=1; next state FLUSH with counter=FLUSH_LEN-1; if FLUSH_LEN=1, next state RUN.
REQ-007 FLUSH: flush_if_id_o=1 and counter decrements each cycle; the FSM leaves for RUN in the cycle the counter reads 1; jump_req_i, ex_busy_i and load-use are ignored in FLUSH.
REQ-008 RUN, no jump, ex_busy_i=1: hold_pc_o, hold_if_id_o and hold_id_ex_o all =1; next state STALL.
REQ-009 STALL, ex_busy_i=1: all three holds =1 and the stall counter increments, saturating at STALL_TIMEOUT.
REQ-010 STALL, ex_busy_i=0: no holds; next state RUN; the stall counter clears.
REQ-011 STALL: jump_req_i and load-use are ignored.
REQ-012 Load-use hazard = ex_is_load_i & ex_rd_we_i & ex_rd_addr_i!=0 & ((id_rs1_re_i & rs1 match) | (id_rs2_re_i & rs2 match)).
REQ-013 RUN, hazard, no jump, not busy: hold_pc_o=1, hold_if_id_o=1, flush_id_ex_o=1 for that cycle only; the FSM stays in RUN.
REQ-014 SHALL pulse timeout_o for exactly one cycle, in the cycle the stall counter transitions to STALL_TIMEOUT; it SHALL NOT re-pulse until the counter clears.
REQ-015 When jump_o=0, jump_addr_o SHALL be 0.
REQ-016 Hold and flush to the same register SHALL never both be 1 in the same cycle.

Reset
REQ-017 rst=1 at a clock edge SHALL set the state to RUN, the flush counter to 0 and the stall counter to 0, and SHALL clear the performance counters when present.
REQ-018 While rst=1, all outputs SHALL be 0 regardless of state and inputs.
REQ-019 Reset asserted in STALL or FLUSH SHALL return the FSM to RUN on the next cycle with no residual flush or hold.

Configuration
REQ-020 SHALL use macro PIPE_CTRL_PERF_CNT_EN.
REQ-021 With PIPE_CTRL_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt_o[31:0] (+1 per cycle with any hold asserted) and flush_cnt_o[31:0] (+1 per jump_o pulse); both wrap from 0xFFFFFFFF to 0.
REQ-022 With PIPE_CTRL_PERF_CNT_EN undefined, these ports and their registers SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-023 FLUSH_LEN=2: pulse jump_req_i for one cycle with jump_addr_i=0x80 -> that cycle jump_o=1, jump_addr_o=0x80, both flushes=1; next cycle flush_if_id_o=1 only; then RUN.
REQ-024 ex_is_load_i=1, ex_rd_we_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_rs2_re_i=1 -> one cycle of hold_pc_o, hold_if_id_o and flush_id_ex_o; same stimulus with ex_rd_addr_i=0 -> no stall.
REQ-025 ex_busy_i high for 3 cycles -> holds high for exactly those 3 cycles; the cycle ex_busy_i falls -> holds 0, state RUN.
REQ-026 STALL_TIMEOUT=4, ex_busy_i high for 10 cycles -> timeout_o pulses exactly once, on the 5th busy cycle.
REQ-027 jump_req_i, ex_busy_i and load-use hazard all asserted in the same RUN cycle -> jump behaviour only, no holds; rst asserted during FLUSH -> RUN next cycle, all outputs 0.
